// File: rtl/noc_credit_rx_buffer.sv
// ---------------------------------------------------------------------------
// noc_credit_rx_buffer
//   Receive-side endpoint of a credit-based NoC link. Incoming flits are
//   stored in per-VC FIFOs and drained through a round-robin arbiter into a
//   registered output stage. Each flit that leaves its FIFO returns one
//   credit to the upstream as a one-cycle pulse on credit_ret.
//
//   Optional build macro: NOC_CREDIT_RX_BYPASS_EN
//     When defined, a flit arriving while every FIFO is empty and the output
//     stage can load goes straight into the output register (1-cycle latency).
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   in_valid/vc/data  incoming flit (always accepted, no ready)
//   out_valid/vc/data registered output flit
//   out_ready         consumer accept
//   credit_ret        per-VC one-cycle credit pulse (registered, one-hot)
//   vc_empty          per-VC FIFO empty flag (combinational)
//   ovf_err           per-VC sticky overflow flag
// ---------------------------------------------------------------------------

// Per-VC storage: simple circular FIFO with occupancy count.
module noc_credit_rx_fifo #(
    parameter int DATA_WIDTH = 64,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  empty,
    output logic                  full
);
    localparam int PW = $clog2(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [PW:0]           count;

    // Storage is not reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // When full, wr_ptr == rd_ptr; a same-cycle push+pop reads the old head
    // combinationally before the edge overwrites that slot.
    assign rdata = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == (PW+1)'(FIFO_DEPTH));
endmodule

module noc_credit_rx_buffer #(
    parameter int VC_NUM     = 4,
    parameter int DATA_WIDTH = 64,
    parameter int FIFO_DEPTH = 16,
    localparam int VC_W      = (VC_NUM > 1) ? $clog2(VC_NUM) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [VC_W-1:0]       in_vc,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic [VC_W-1:0]       out_vc,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic [VC_NUM-1:0]     credit_ret,
    output logic [VC_NUM-1:0]     vc_empty,
    output logic [VC_NUM-1:0]     ovf_err
);
    typedef struct packed {
        logic [VC_W-1:0]       vc;
        logic [DATA_WIDTH-1:0] data;
    } flit_t;

    flit_t                            out_q;
    logic                             out_vld;
    logic [VC_W-1:0]                  rr_ptr;

    logic [VC_NUM-1:0]                fifo_empty, fifo_full;
    logic [VC_NUM-1:0]                push, pop, ovf_set;
    logic [VC_NUM-1:0][DATA_WIDTH-1:0] fifo_rdata;

    logic                             load_en;
    logic                             bypass;
    logic                             gnt_any;
    logic [VC_W-1:0]                  gnt_vc;

    assign load_en = !out_vld || out_ready;

`ifdef NOC_CREDIT_RX_BYPASS_EN
    // Only legal when nothing is queued, so ordering within a VC is kept.
    assign bypass = (&fifo_empty) && load_en && in_valid;
`else
    assign bypass = 1'b0;
`endif

    // Round-robin: first non-empty VC after rr_ptr, wrapping modulo VC_NUM.
    always_comb begin
        int              idx;
        logic [VC_W-1:0] sel;
        gnt_any = 1'b0;
        gnt_vc  = '0;
        idx     = 0;
        sel     = '0;
        for (int i = 1; i <= VC_NUM; i++) begin
            idx = (int'(rr_ptr) + i) % VC_NUM;
            sel = VC_W'(idx);
            if (!gnt_any && !fifo_empty[sel]) begin
                gnt_any = 1'b1;
                gnt_vc  = sel;
            end
        end
    end

    for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
        logic hit;
        assign hit        = in_valid && (in_vc == VC_W'(v));
        assign pop[v]     = load_en && gnt_any && (gnt_vc == VC_W'(v));
        // Capacity is judged after this cycle's pop.
        assign push[v]    = hit && !bypass && (!fifo_full[v] || pop[v]);
        assign ovf_set[v] = hit && fifo_full[v] && !pop[v];

        noc_credit_rx_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push[v]),
            .pop   (pop[v]),
            .wdata (in_data),
            .rdata (fifo_rdata[v]),
            .empty (fifo_empty[v]),
            .full  (fifo_full[v])
        );
    end

    // Output stage, arbiter state, credit pulse and sticky overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q      <= '0;
            out_vld    <= 1'b0;
            rr_ptr     <= VC_W'(VC_NUM - 1);
            credit_ret <= '0;
            ovf_err    <= '0;
        end else begin
            credit_ret <= '0;
            ovf_err    <= ovf_err | ovf_set;
            if (load_en) begin
                if (gnt_any) begin
                    out_vld    <= 1'b1;
                    out_q.vc   <= gnt_vc;
                    out_q.data <= fifo_rdata[gnt_vc];
                    rr_ptr     <= gnt_vc;
                    credit_ret <= VC_NUM'(1) << gnt_vc;
                end else if (bypass) begin
                    out_vld    <= 1'b1;
                    out_q.vc   <= in_vc;
                    out_q.data <= in_data;
                    rr_ptr     <= in_vc;
                    credit_ret <= VC_NUM'(1) << in_vc;
                end else begin
                    out_vld    <= 1'b0;
                end
            end
        end
    end

    assign out_valid = out_vld;
    assign out_vc    = out_q.vc;
    assign out_data  = out_q.data;
    assign vc_empty  = fifo_empty;
endmodule

// File: tb/tb_noc_credit_rx_buffer.sv
// ---------------------------------------------------------------------------
// tb_noc_credit_rx_buffer
//   Directed bench for noc_credit_rx_buffer. A queue-based reference model
//   advances on each clock edge; a negedge process compares every output
//   against it, and directed sections pin literal expectations.
//   Honors NOC_CREDIT_RX_BYPASS_EN for the single-flit latency check.
// ---------------------------------------------------------------------------
module tb_noc_credit_rx_buffer;
    localparam int VC_NUM = 4;
    localparam int DW     = 64;
    localparam int DEPTH  = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [1:0]    in_vc = '0;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic [1:0]    out_vc;
    logic [DW-1:0] out_data;
    logic          out_ready = 1'b0;
    logic [3:0]    credit_ret, vc_empty, ovf_err;

    noc_credit_rx_buffer #(.VC_NUM(VC_NUM), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_vc      (in_vc),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_vc     (out_vc),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .credit_ret (credit_ret),
        .vc_empty   (vc_empty),
        .ovf_err    (ovf_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [DW-1:0] mq [VC_NUM][$];
    logic          m_ov;
    int            m_vc;
    logic [DW-1:0] m_data;
    logic [3:0]    m_cr, m_ovf;
    int            m_rr;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int v = 0; v < VC_NUM; v++) mq[v].delete();
            m_ov = 1'b0; m_vc = 0; m_data = '0; m_cr = '0; m_ovf = '0;
            m_rr = VC_NUM - 1;
        end else begin
            int g;
            bit byp;
            g = -1; byp = 0; m_cr = '0;
            if (!m_ov || out_ready) begin
                for (int k = 1; k <= VC_NUM; k++)
                    if (g < 0 && mq[(m_rr + k) % VC_NUM].size() > 0) g = (m_rr + k) % VC_NUM;
                if (g >= 0) begin
                    m_ov = 1'b1; m_vc = g; m_data = mq[g].pop_front(); m_rr = g;
                    m_cr = 4'(1 << g);
                end
`ifdef NOC_CREDIT_RX_BYPASS_EN
                else if (in_valid) begin
                    byp = 1; m_ov = 1'b1; m_vc = int'(in_vc); m_data = in_data;
                    m_rr = int'(in_vc); m_cr = 4'(1 << in_vc);
                end
`endif
                else m_ov = 1'b0;
            end
            if (in_valid && !byp) begin
                if (mq[in_vc].size() < DEPTH) mq[in_vc].push_back(in_data);
                else m_ovf[in_vc] = 1'b1;
            end
        end
    end

    // ---------------- per-cycle compare + logging ----------------
    int            credcnt [VC_NUM];
    int            acc_vc [$];
    logic [DW-1:0] acc_data [$];

    always @(negedge clk) begin
        logic [3:0] m_empty;
        for (int v = 0; v < VC_NUM; v++) m_empty[v] = (mq[v].size() == 0);
        chk("out_valid", out_valid, m_ov);
        if (m_ov) begin
            chk("out_vc", out_vc, m_vc);
            chk("out_data", out_data, m_data);
        end
        chk("credit_ret", credit_ret, m_cr);
        chk("vc_empty", vc_empty, m_empty);
        chk("ovf_err", ovf_err, m_ovf);
        if (!rst) begin
            for (int v = 0; v < VC_NUM; v++) if (credit_ret[v]) credcnt[v]++;
            if (out_valid && out_ready) begin
                acc_vc.push_back(int'(out_vc));
                acc_data.push_back(out_data);
            end
        end
    end

    // Inputs change 1 time unit after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int vc, input logic [DW-1:0] d);
        in_valid = 1'b1; in_vc = 2'(vc); in_data = d;
        cyc();
        in_valid = 1'b0;
    endtask

    initial begin
        bit ok;
        for (int v = 0; v < VC_NUM; v++) credcnt[v] = 0;
        repeat (3) cyc();
        // Reset state
        chk("rst out_valid", out_valid, 0);
        chk("rst credit_ret", credit_ret, 0);
        chk("rst vc_empty", vc_empty, 4'b1111);
        chk("rst ovf_err", ovf_err, 0);
        rst = 1'b0;
        cyc();

        // ---- single flit latency ----
        out_ready = 1'b1;
        send(2, 64'hA5);
`ifndef NOC_CREDIT_RX_BYPASS_EN
        chk("lat early out_valid", out_valid, 0);
        cyc();
`endif
        chk("single out_valid", out_valid, 1);
        chk("single out_vc", out_vc, 2);
        chk("single out_data", out_data, 64'hA5);
        chk("single credit", credit_ret, 4'b0100);
        cyc();
        chk("single credit gone", credit_ret, 0);
        chk("single drained", out_valid, 0);

        // ---- overflow on VC0 with consumer stalled ----
        for (int v = 0; v < VC_NUM; v++) credcnt[v] = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 18; i++) send(0, 64'(i));
        cyc();
        chk("ovf flag", ovf_err, 4'b0001);
        chk("ovf credits", credcnt[0], 1);
        acc_vc.delete(); acc_data.delete();
        out_ready = 1'b1;
        repeat (20) cyc();
        chk("ovf drained count", acc_data.size(), 17);
        ok = (acc_data.size() == 17);
        for (int i = 0; i < 17 && ok; i++) if (acc_data[i] != 64'(i)) ok = 0;
        chk("ovf drain order", ok, 1);
        chk("ovf total credits", credcnt[0], 17);

        // ---- round-robin order ----
        out_ready = 1'b0;
        send(0, 64'h30); send(1, 64'h31); send(3, 64'h33);
        send(0, 64'h40); send(1, 64'h41); send(3, 64'h43);
        cyc();
        acc_vc.delete(); acc_data.delete();
        out_ready = 1'b1;
        repeat (6) cyc();
        chk("rr count", acc_vc.size(), 6);
        if (acc_vc.size() == 6) begin
            chk("rr vc seq", {acc_vc[0][1:0], acc_vc[1][1:0], acc_vc[2][1:0],
                              acc_vc[3][1:0], acc_vc[4][1:0], acc_vc[5][1:0]}, 12'b00_01_11_00_01_11);
            chk("rr data0", acc_data[0], 64'h30);
            chk("rr data2", acc_data[2], 64'h33);
            chk("rr data5", acc_data[5], 64'h43);
        end
        chk("rr all empty", vc_empty, 4'b1111);
        chk("rr idle", out_valid, 0);

        // ---- push into full VC1 while it pops ----
        out_ready = 1'b0;
        for (int i = 0; i < 17; i++) send(1, 64'h100 + 64'(i));
        cyc();
        acc_vc.delete(); acc_data.delete();
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) send(1, 64'h200 + 64'(k));
        chk("full pop no ovf", ovf_err, 4'b0001);
        repeat (20) cyc();
        chk("full drained count", acc_data.size(), 20);
        if (acc_data.size() == 20) begin
            chk("full data16", acc_data[16], 64'h110);
            chk("full data17", acc_data[17], 64'h200);
            chk("full data19", acc_data[19], 64'h202);
        end

        // ---- asynchronous reset mid-stream ----
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) send(i % 4, 64'h50 + 64'(i));
        cyc();
        chk("pre-rst out_valid", out_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("async out_valid", out_valid, 0);
        chk("async credit", credit_ret, 0);
        chk("async ovf", ovf_err, 0);
        chk("async vc_empty", vc_empty, 4'b1111);
        acc_vc.delete(); acc_data.delete();
        cyc();
        rst = 1'b0;
        out_ready = 1'b1;
        send(3, 64'hC3);
        repeat (3) cyc();
        chk("post-rst count", acc_data.size(), 1);
        if (acc_data.size() == 1) begin
            chk("post-rst vc", acc_vc[0], 3);
            chk("post-rst data", acc_data[0], 64'hC3);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/noc_credit_rx_buffer.md
Name: noc_credit_rx_buffer

Overview:
- Receive-side endpoint of the NoC credit-based link, sitting downstream of the upstream credit flow-control stage.
- Accepts flits tagged with a VC and stores them in per-VC FIFOs. Flits drain to the local consumer through a round-robin arbiter and a registered output stage.
- Returns one credit per VC pulse whenever a flit leaves its FIFO.
- The upstream initialises its credit counters to FIFO_DEPTH; this block never back-pressures the link.

Parameters:
- VC_NUM, 4, number of virtual channels.
- DATA_WIDTH, 64, flit payload width.
- FIFO_DEPTH, 16, entries per VC FIFO; power of 2, at least 2.
- VC_W, $clog2(VC_NUM), VC index width (local, derived).

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  flit present on link this cycle; no ready signal, always sampled.
- in_vc  in  VC_W  VC of incoming flit.
- in_data  in  DATA_WIDTH  incoming flit payload.
- out_valid  out  1  output register holds a flit.
- out_vc  out  VC_W  VC of output flit.
- out_data  out  DATA_WIDTH  output flit payload.
- out_ready  in  1  consumer accepts flit when out_valid and out_ready are both high.
- credit_ret  out  VC_NUM  per-VC one-cycle credit-return pulse; each set bit returns 1 credit.
- vc_empty  out  VC_NUM  combinational per-VC FIFO-empty flag.
- ovf_err  out  VC_NUM  sticky per-VC overflow flag.

Behaviour:
- Clock/reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - out_valid=0, out_vc=0, out_data=0, credit_ret=0, ovf_err=0, vc_empty=all 1s.
  - All FIFO pointers and counts cleared.
  - Round-robin pointer set to VC_NUM-1, so VC0 has first priority.
- Reset mid-operation:
  - All queued flits and the output register contents are discarded.
  - No credit pulses are emitted for discarded flits.
  - The upstream re-initialises its credits on its own reset.
- Push:
  - When in_valid=1 and FIFO[in_vc] count is below FIFO_DEPTH, the flit is written at the clock edge.
  - When the FIFO is full, the flit is dropped, ovf_err[in_vc] is set (sticky until rst), and no credit is returned for it.
- Pop condition: load_en = !out_valid OR out_ready.
  - When load_en=1 and any VC is non-empty, the arbiter grants the first non-empty VC, searching from rr_ptr+1 with modulo VC_NUM wrap.
  - The head flit is moved into the output register and rr_ptr is set to the granted VC.
  - When no VC is non-empty and out_ready=1, out_valid drops to 0.
- Credit return:
  - credit_ret is a register. On the edge that pops VC v, credit_ret is set to the one-hot value of v; otherwise it is 0.
  - At most one credit bit is set per cycle.
  - credit_ret therefore rises in the same cycle out_valid first presents that flit.
- Latency:
  - Flit sampled at edge T; out_valid can be high after edge T+1 at the earliest (2-cycle push-to-output).
  - Sustained throughput is 1 flit per cycle.
- Simultaneous push and pop on the same VC:
  - Both take effect; count is unchanged.
  - A push into a full FIFO in the same cycle as a pop from that VC is legal and is not an overflow. Capacity is checked after the pop.
- Output stability: out_vc and out_data hold stable while out_valid=1 and out_ready=0.
- Pointer arithmetic: FIFO pointers are log2(FIFO_DEPTH) wide and wrap naturally. Count width is log2(FIFO_DEPTH)+1.

Optional Feature:
- Macro: NOC_CREDIT_RX_BYPASS_EN.
- Defined:
  - If all FIFOs are empty, load_en=1 and in_valid=1, the incoming flit goes directly into the output register, skipping its FIFO.
  - Latency becomes 1 cycle (out_valid high after edge T).
  - credit_ret[in_vc] pulses in the same cycle. rr_ptr is updated to in_vc.
- Undefined: every flit passes through its FIFO and the 2-cycle latency applies.

Test Plan:
- Single flit in_vc=2, in_data=0xA5, out_ready=1 at edge 0 -> after edge 1: out_valid=1, out_vc=2, out_data=0xA5, credit_ret=4'b0100 for exactly 1 cycle. With bypass defined, the same response appears after edge 0.
- out_ready=0, 18 back-to-back flits on VC0 -> 17 retained (1 in output register, 16 in FIFO); 18th dropped; ovf_err=4'b0001; exactly one credit_ret[0] pulse. Raising out_ready then drains 17 flits in order and produces 16 further credit_ret[0] pulses.
- Preload 2 flits each on VC0, VC1 and VC3, then out_ready=1 -> output VC order 0,1,3,0,1,3 on consecutive cycles; vc_empty=4'b1111 afterwards; no gaps.
- VC1 full (16 entries) with the output register draining; push to VC1 in the same cycle as a VC1 pop -> no overflow, ovf_err[1]=0, count stays 16.
- 5 flits queued and out_valid=1, then assert rst for 1 cycle mid-stream -> out_valid=0, credit_ret=0, ovf_err=0, vc_empty=all 1s immediately (asynchronous). After reset, a new flit on VC3 is output as the first flit.
